// File: rtl/bus_sram_ctrl.sv
// Bus-to-SRAM slave controller: one transaction at a time, range/alignment
// checks, and read-modify-write for partial-strobe writes on a byte-enable-less SRAM.

package bus_sram_ctrl_pkg;
  typedef enum logic {
    BUS_CMD_READ  = 1'b0,
    BUS_CMD_WRITE = 1'b1
  } bus_cmd_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR  = 3'd1,
    ACC  = 3'd2,
    RDW  = 3'd3,
    WR   = 3'd4,
    RSP  = 3'd5
  } state_t;
endpackage

// Handshake: a request transfers on a cycle with req_vld && req_rdy, a response
// on a cycle with rsp_vld && rsp_rdy; the valid side holds its packet stable
// until that cycle, and neither ready nor valid depends on the other side.
interface bus_trans_if_t #(
  parameter int AW = 32,
  parameter int DW = 32
);
  import bus_sram_ctrl_pkg::*;

  typedef struct packed {
    bus_cmd_t          cmd;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     data;
    logic [DW/8-1:0]   strobe;
  } req_pkt_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ok;
  } rsp_pkt_t;

  logic     req_vld;
  logic     req_rdy;
  req_pkt_t req_pkt;
  logic     rsp_vld;
  logic     rsp_rdy;
  rsp_pkt_t rsp_pkt;

  modport slave  (input req_vld, req_pkt, rsp_rdy, output req_rdy, rsp_vld, rsp_pkt);
  modport master (output req_vld, req_pkt, rsp_rdy, input req_rdy, rsp_vld, rsp_pkt);
endinterface

interface sram_if_t #(
  parameter int SAW = 15,
  parameter int DW  = 32
);
  logic [SAW-1:0] addr;
  logic           wen;
  logic [DW-1:0]  wdata;
  logic [DW-1:0]  rdata;

  modport master (output addr, wen, wdata, input rdata);
  modport slave  (input addr, wen, wdata, output rdata);
endinterface

module bus_sram_ctrl
  import bus_sram_ctrl_pkg::*;
#(
  parameter int            AW   = 32,
  parameter int            DW   = 32,
  parameter int            SAW  = 15,
  parameter logic [AW-1:0] BASE = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_trans_if_t.slave  bus,
  sram_if_t.master      sram,
  output state_t        dbg_state
);

  localparam int SB = DW / 8;
  localparam int OB = $clog2(SB);
  localparam logic [AW:0] LIMIT = {1'b0, BASE} + ((AW + 1)'(1) << (SAW + OB));

  state_t         state;
  logic           is_wr_q;
  logic           err_q;
  logic [SB-1:0]  strobe_q;
  logic [SAW-1:0] idx_q;
  logic [DW-1:0]  wdata_q;
  logic [DW-1:0]  rsp_data_q;
  logic           rsp_ok_q;
  logic           wen_q;

  logic           req_err;
  logic           req_is_wr;
  logic [SAW-1:0] req_idx;

  assign req_err = ((bus.req_pkt.addr & AW'(SB - 1)) != '0)
                || (bus.req_pkt.addr < BASE)
                || ({1'b0, bus.req_pkt.addr} >= LIMIT);
  assign req_is_wr = (bus.req_pkt.cmd == BUS_CMD_WRITE);
  assign req_idx   = SAW'((bus.req_pkt.addr - BASE) >> OB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_wr_q    <= 1'b0;
      err_q      <= 1'b0;
      strobe_q   <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_ok_q   <= 1'b0;
      wen_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_vld) begin
            is_wr_q  <= req_is_wr;
            err_q    <= req_err;
            strobe_q <= bus.req_pkt.strobe;
            idx_q    <= req_idx;
            wdata_q  <= bus.req_pkt.data;
            // Zero-strobe writes also take the ERR path (with ok=1) so they
            // share the two-cycle no-access latency of rejected requests.
            if (req_err || (req_is_wr && bus.req_pkt.strobe == '0)) begin
              state <= ERR;
            end else begin
              state <= ACC;
              wen_q <= req_is_wr && (&bus.req_pkt.strobe);
            end
          end
        end
        ERR: begin
          rsp_data_q <= '0;
          rsp_ok_q   <= ~err_q;
          state      <= RSP;
        end
        ACC: begin
          wen_q <= 1'b0;
          if (is_wr_q && (&strobe_q)) begin
            rsp_data_q <= '0;
            rsp_ok_q   <= 1'b1;
            state      <= RSP;
          end else begin
            state <= RDW;
          end
        end
        RDW: begin
          if (!is_wr_q) begin
            rsp_data_q <= sram.rdata;
            rsp_ok_q   <= 1'b1;
            state      <= RSP;
          end else begin
            // Keep strobed bytes of the request, fill the rest from the old word.
            for (int i = 0; i < SB; i++) begin
              if (!strobe_q[i]) wdata_q[8*i +: 8] <= sram.rdata[8*i +: 8];
            end
            wen_q <= 1'b1;
            state <= WR;
          end
        end
        WR: begin
          wen_q      <= 1'b0;
          rsp_data_q <= '0;
          rsp_ok_q   <= 1'b1;
          state      <= RSP;
        end
        RSP: begin
          if (bus.rsp_rdy) state <= IDLE;
        end
        default: begin
          wen_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_rdy = (state == IDLE);
  assign bus.rsp_vld = (state == RSP);
  assign bus.rsp_pkt = {rsp_data_q, rsp_ok_q};
  assign sram.addr   = idx_q;
  assign sram.wen    = wen_q;
  assign sram.wdata  = wdata_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_bus_sram_ctrl.sv
// Self-checking bench for bus_sram_ctrl: behavioural SRAM, expected-response
// queue filled at request time and drained when the DUT answers.
module tb_bus_sram_ctrl;
  import bus_sram_ctrl_pkg::*;

  localparam int P = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #(P/2) clk = ~clk;

  bus_trans_if_t #(.AW(32), .DW(32)) bus ();
  sram_if_t #(.SAW(15), .DW(32)) sram ();
  state_t dbg_state;

  bus_sram_ctrl #(.AW(32), .DW(32), .SAW(15), .BASE(32'h0000_0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sram      (sram),
    .dbg_state (dbg_state)
  );

  // Behavioural synchronous SRAM: read data appears the cycle after the access.
  logic [31:0] mem [0:32767];
  always @(posedge clk) begin
    if (sram.wen) mem[sram.addr] <= sram.wdata;
    sram.rdata <= mem[sram.addr];
  end

  int wen_cnt = 0;
  int acc_cnt = 0;
  always @(posedge clk) begin
    if (sram.wen) wen_cnt++;
    if (dbg_state == ACC) acc_cnt++;
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int          lat_q[$];
  time         t_acc;
  int          checks = 0;
  int          errors = 0;

  // ---------------- driver tasks ----------------
  // Called on a negedge; drives the request there so it is accepted on the next posedge.
  task automatic send(input bus_cmd_t cmd, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [31:0] exp_data, input logic exp_ok,
                      input int exp_lat, output int waited);
    waited = 0;
    while (!bus.req_rdy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL req_rdy_wait: req_rdy=%b required 1", bus.req_rdy);
    end
    bus.req_vld = 1'b1;
    bus.req_pkt.cmd = cmd;
    bus.req_pkt.addr = addr;
    bus.req_pkt.data = data;
    bus.req_pkt.strobe = strb;
    exp_q.push_back({exp_data, exp_ok});
    lat_q.push_back(exp_lat);
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    bus.req_vld = 1'b0;
    checks++;
    if (bus.req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL accept: req_rdy=%b required 0 after accept", bus.req_rdy);
    end
  endtask

  task automatic get_rsp(input int stall);
    int n = 0;
    int lat;
    int lat_exp;
    logic [32:0] exp;
    logic [32:0] got;
    while (!bus.rsp_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    exp = exp_q.pop_front();
    lat_exp = lat_q.pop_front();
    checks++;
    if (bus.rsp_vld !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_vld=%b required 1 within 50 cycles", bus.rsp_vld);
      return;
    end
    lat = int'(($time - t_acc - P/2) / P) + 1;
    checks++;
    if (lat !== lat_exp) begin
      errors++;
      $display("FAIL latency: got T%0d required T%0d", lat, lat_exp);
    end
    got = {bus.rsp_pkt.data, bus.rsp_pkt.ok};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rsp_pkt: data=%h ok=%b required data=%h ok=%b", got[32:1], got[0], exp[32:1], exp[0]);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_pkt.data, bus.rsp_pkt.ok} !== got || bus.rsp_vld !== 1'b1 || bus.req_rdy !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d pkt=%h vld=%b req_rdy=%b required pkt=%h vld=1 req_rdy=0",
                 i, {bus.rsp_pkt.data, bus.rsp_pkt.ok}, bus.rsp_vld, bus.req_rdy, got);
      end
    end
    bus.rsp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_rdy = 1'b0;
    checks++;
    if (bus.rsp_vld !== 1'b0 || bus.req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL post_handshake: rsp_vld=%b req_rdy=%b required 0/1", bus.rsp_vld, bus.req_rdy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (bus.req_rdy !== 1'b1 || bus.rsp_vld !== 1'b0 || sram.wen !== 1'b0 || sram.addr !== 15'd0 ||
        sram.wdata !== 32'd0 || bus.rsp_pkt !== 33'd0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_values: rdy=%b vld=%b wen=%b addr=%h wdata=%h pkt=%h st=%0d required 1/0/0/0/0/0/0",
               bus.req_rdy, bus.rsp_vld, sram.wen, sram.addr, sram.wdata, bus.rsp_pkt, dbg_state);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_rdy !== 1'b1 || bus.rsp_vld !== 1'b0 || sram.wen !== 1'b0) begin
      errors++;
      $display("FAIL idle_values: rdy=%b vld=%b wen=%b required 1/0/0", bus.req_rdy, bus.rsp_vld, sram.wen);
    end
  endtask

  task automatic test_full_write_read();
    int w0, a0, wt;
    w0 = wen_cnt;
    a0 = acc_cnt;
    send(BUS_CMD_WRITE, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1, 2, wt);
    checks++;
    if (sram.wen !== 1'b1 || sram.addr !== 15'd4 || sram.wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL full_write_t1: wen=%b addr=%h wdata=%h required 1/4/deadbeef", sram.wen, sram.addr, sram.wdata);
    end
    get_rsp(0);
    checks++;
    if (wen_cnt - w0 !== 1 || mem[4] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL full_write_mem: wen_pulses=%0d word4=%h required 1/deadbeef", wen_cnt - w0, mem[4]);
    end
    send(BUS_CMD_READ, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 3, wt);
    get_rsp(0);
    checks++;
    if (acc_cnt - a0 !== 2) begin
      errors++;
      $display("FAIL full_write_acc: acc_cycles=%0d required 2", acc_cnt - a0);
    end
  endtask

  task automatic test_partial_write();
    int w0, wt;
    w0 = wen_cnt;
    send(BUS_CMD_WRITE, 32'h10, 32'h00AA_0055, 4'b0101, 32'h0, 1'b1, 4, wt);
    get_rsp(0);
    checks++;
    if (wen_cnt - w0 !== 1 || mem[4] !== 32'hDEAA_BE55) begin
      errors++;
      $display("FAIL partial_write_mem: wen_pulses=%0d word4=%h required 1/deaabe55", wen_cnt - w0, mem[4]);
    end
    send(BUS_CMD_READ, 32'h10, 32'h0, 4'h0, 32'hDEAA_BE55, 1'b1, 3, wt);
    get_rsp(0);
  endtask

  task automatic test_errors();
    int w0, a0, wt;
    w0 = wen_cnt;
    a0 = acc_cnt;
    send(BUS_CMD_READ, 32'h12, 32'h0, 4'h0, 32'h0, 1'b0, 2, wt);
    get_rsp(0);
    send(BUS_CMD_WRITE, 32'h0002_0000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, 2, wt);
    get_rsp(0);
    send(BUS_CMD_WRITE, 32'h13, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 2, wt);
    get_rsp(0);
    checks++;
    if (wen_cnt - w0 !== 0 || acc_cnt - a0 !== 0) begin
      errors++;
      $display("FAIL error_no_access: wen_pulses=%0d acc_cycles=%0d required 0/0", wen_cnt - w0, acc_cnt - a0);
    end
    // Last valid word just below the range limit.
    send(BUS_CMD_WRITE, 32'h0001_FFFC, 32'hA5A5_5A5A, 4'hF, 32'h0, 1'b1, 2, wt);
    get_rsp(0);
    send(BUS_CMD_READ, 32'h0001_FFFC, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b1, 3, wt);
    get_rsp(0);
  endtask

  task automatic test_zero_strobe();
    int w0, a0, wt;
    w0 = wen_cnt;
    a0 = acc_cnt;
    send(BUS_CMD_WRITE, 32'h10, 32'h1234_5678, 4'h0, 32'h0, 1'b1, 2, wt);
    get_rsp(0);
    checks++;
    if (wen_cnt - w0 !== 0 || acc_cnt - a0 !== 0) begin
      errors++;
      $display("FAIL zero_strobe_access: wen_pulses=%0d acc_cycles=%0d required 0/0", wen_cnt - w0, acc_cnt - a0);
    end
    send(BUS_CMD_READ, 32'h10, 32'h0, 4'h0, 32'hDEAA_BE55, 1'b1, 3, wt);
    get_rsp(0);
  endtask

  task automatic test_back_to_back();
    int wt;
    send(BUS_CMD_READ, 32'h10, 32'h0, 4'h0, 32'hDEAA_BE55, 1'b1, 3, wt);
    get_rsp(5);
    send(BUS_CMD_READ, 32'h0001_FFFC, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b1, 3, wt);
    checks++;
    if (wt !== 0) begin
      errors++;
      $display("FAIL back_to_back_accept: waited=%0d cycles required 0", wt);
    end
    get_rsp(2);
  endtask

  task automatic test_random();
    logic [31:0] ref_w [8];
    logic [31:0] d;
    logic [3:0]  s;
    int          i, lat, wt;
    for (int k = 0; k < 8; k++) begin
      d = $urandom;
      send(BUS_CMD_WRITE, 32'h40 + 32'(4 * k), d, 4'hF, 32'h0, 1'b1, 2, wt);
      get_rsp(0);
      ref_w[k] = d;
    end
    for (int k = 0; k < 10; k++) begin
      i = $urandom_range(0, 7);
      s = 4'($urandom_range(0, 15));
      d = $urandom;
      lat = (s == 4'h0 || s == 4'hF) ? 2 : 4;
      send(BUS_CMD_WRITE, 32'h40 + 32'(4 * i), d, s, 32'h0, 1'b1, lat, wt);
      get_rsp($urandom_range(0, 2));
      for (int b = 0; b < 4; b++) begin
        if (s[b]) ref_w[i][8*b +: 8] = d[8*b +: 8];
      end
    end
    for (int k = 0; k < 8; k++) begin
      send(BUS_CMD_READ, 32'h40 + 32'(4 * k), 32'h0, 4'h0, ref_w[k], 1'b1, 3, wt);
      get_rsp($urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    int n, wt;
    send(BUS_CMD_READ, 32'h10, 32'h0, 4'h0, 32'h0, 1'b1, 3, wt);
    n = 0;
    while (dbg_state != RDW && n < 10) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dbg_state !== IDLE || sram.wen !== 1'b0 || bus.req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_rdw: state=%0d wen=%b req_rdy=%b required 0/0/1", dbg_state, sram.wen, bus.req_rdy);
    end
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    // Partial write interrupted while the write pulse is high.
    @(negedge clk);
    send(BUS_CMD_WRITE, 32'h190, 32'h1111_1111, 4'b0011, 32'h0, 1'b1, 4, wt);
    n = 0;
    while (dbg_state != WR && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sram.wen !== 1'b1) begin
      errors++;
      $display("FAIL wr_wen: wen=%b required 1 in WR", sram.wen);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sram.wen !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_in_wr: wen=%b state=%0d required 0/0", sram.wen, dbg_state);
    end
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.rsp_vld !== 1'b0) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL no_rsp_after_reset: rsp_vld seen %0d cycles required 0", n);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.req_vld = 1'b0;
    bus.req_pkt = '0;
    bus.rsp_rdy = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_errors();
    test_zero_strobe();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
